vproc_div_seq: RTL and testbench

VPROC_DIV_SEQ -- requirements
Module: vproc_div_seq

---
 rtl/vproc_pkg.sv | 38 +++
 rtl/vproc_div_seq_if.sv | 47 ++++
 rtl/vproc_div_iter.sv | 65 ++++++
 rtl/vproc_div_seq.sv | 214 +++++++++++++++++++++
 tb/tb_vproc_div_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vproc_pkg.sv
// Shared types for the vector divide sequencer.
// Holds the element-width and operation encodings used across the vector
// datapath. It also holds the sequencer state enum and a helper that maps an
// element width to its size in bits.
// No ports; imported by vproc_div_seq_if, vproc_div_seq and the testbench.
package vproc_pkg;

   typedef enum logic [1:0] {
      VSEW_8       = 2'd0,
      VSEW_16      = 2'd1,
      VSEW_32      = 2'd2,
      VSEW_INVALID = 2'd3
   } vsew;

   typedef enum logic {
      DIV_VDIV = 1'b0,
      DIV_VREM = 1'b1
   } div_op;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ITER  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } div_seq_state_e;

   // An unsupported width code falls back to 32-bit elements, so a bad
   // code still gives a job that terminates.
   function automatic logic [5:0] eew_bits(vsew eew);
      case (eew)
         VSEW_8:  return 6'd8;
         VSEW_16: return 6'd16;
         default: return 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/vproc_div_seq_if.sv
// Handshake and data bundle between a job producer and vproc_div_seq.
// Ports:
//   Input side:  in_valid_i / in_ready_o handshake, plus in_ctrl_i,
//                in_eew_i, in_op_i, in_signed_i, in_op1_i, in_op2_i and
//                in_mask_i.
//   Output side: out_valid_o / out_ready_i handshake, plus out_ctrl_o,
//                out_res_o and out_mask_o.
//   Status:      busy_o.
// Modports: slave is the divider side, master is the producer/consumer side.
interface vproc_div_seq_if
   import vproc_pkg::*;
#(
   parameter int unsigned DIV_OP_W = 64,
   parameter type         CTRL_T   = logic
);

   logic                  in_valid_i;
   logic                  in_ready_o;
   CTRL_T                 in_ctrl_i;
   vsew                   in_eew_i;
   div_op                 in_op_i;
   logic                  in_signed_i;
   logic [DIV_OP_W-1:0]   in_op1_i;
   logic [DIV_OP_W-1:0]   in_op2_i;
   logic [DIV_OP_W/8-1:0] in_mask_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   CTRL_T                 out_ctrl_o;
   logic [DIV_OP_W-1:0]   out_res_o;
   logic [DIV_OP_W/8-1:0] out_mask_o;
   logic                  busy_o;

   modport slave (
      input  in_valid_i, in_ctrl_i, in_eew_i, in_op_i, in_signed_i,
             in_op1_i, in_op2_i, in_mask_i, out_ready_i,
      output in_ready_o, out_valid_o, out_ctrl_o, out_res_o, out_mask_o,
             busy_o
   );

   modport master (
      output in_valid_i, in_ctrl_i, in_eew_i, in_op_i, in_signed_i,
             in_op1_i, in_op2_i, in_mask_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_ctrl_o, out_res_o, out_mask_o,
             busy_o
   );

endinterface

// File: rtl/vproc_div_iter.sv
// Radix-2 restoring unsigned divider for operands of up to 32 bits.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                load op1/op2 and begin dividing
//   width                operand width in bits (8, 16 or 32)
//   op1, op2             dividend and divisor, zero above width
//   quotient, remainder  results, valid in the cycle after done
//   done                 high during the last of the width iteration cycles
module vproc_div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  width,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] quo_q, rem_q, div_q;
   logic [5:0]  cnt_q;
   logic        active_q;
   logic [32:0] shifted, diff;
   logic        fits;

   // One restoring step: bring the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The remainder is always
   // below the divisor, so a borrow out of bit 32 means "does not fit".
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, div_q};
      fits    = ~diff[32];
   end

   // The dividend is left-aligned at bit 31, so any width shifts out MSB
   // first. The quotient bits enter at the bottom of the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         quo_q    <= op1 << (6'd32 - width);
         rem_q    <= '0;
         div_q    <= op2;
         cnt_q    <= width;
         active_q <= 1'b1;
      end else if (active_q) begin
         rem_q <= fits ? diff[31:0] : shifted[31:0];
         quo_q <= {quo_q[30:0], fits};
         cnt_q <= cnt_q - 6'd1;
         if (cnt_q == 6'd1) begin
            active_q <= 1'b0;
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = active_q && (cnt_q == 6'd1);

endmodule

// File: rtl/vproc_div_seq.sv
// Element-sequential vector integer divider (vdiv/vrem, signed/unsigned).
// It accepts one operand word, splits it into DIV_OP_W/EEW elements and
// divides each active element with a shared radix-2 core. It then holds
// the packed result until the consumer takes it.
// Ports:
//   clk_i       clock
//   sync_rst_i  synchronous active-high reset
//   bus         vproc_div_seq_if slave modport (input/output handshakes,
//               operands, mask, control passthrough, busy)
module vproc_div_seq
   import vproc_pkg::*;
#(
   parameter int unsigned DIV_OP_W = 64,
   parameter type         CTRL_T   = logic
) (
   input  logic           clk_i,
   input  logic           sync_rst_i,
   vproc_div_seq_if.slave bus
);

   localparam int unsigned MASK_W = DIV_OP_W / 8;
   localparam int unsigned CNT_W  = $clog2(MASK_W);

   div_seq_state_e      state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [DIV_OP_W-1:0] op1_q, op2_q, res_q;
   logic [MASK_W-1:0]   mask_q;
   CTRL_T               ctrl_q;
   vsew                 eew_q;
   div_op               op_q;
   logic                signed_q, spec_q, qneg_q, rneg_q;
   logic [31:0]         spec_res_q;

   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic [31:0] a32, b32, a_ext, b_ext, mag_a, mag_b, min_ext, spec_res;
   logic [31:0] wr_val, quotient, remainder;
   logic [5:0]  w;
   logic        act8, act16, act32, elem_active, last_elem;
   logic        neg_a, neg_b, div_zero, overflow, special;
   logic        accept, start, write_en, core_done;

   assign accept = (state_q == IDLE) && bus.in_valid_i;
   assign w      = eew_bits(eew_q);

   // Pick out the current element at every width. Its mask bit is the bit
   // of the element's lowest byte.
   always_comb begin
      a8 = '0; b8 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
      act8 = 1'b0; act16 = 1'b0; act32 = 1'b0;
      for (int e = 0; e < MASK_W; e++) begin
         if (CNT_W'(e) == cnt_q) begin
            a8 = op1_q[e*8 +: 8]; b8 = op2_q[e*8 +: 8]; act8 = mask_q[e];
         end
      end
      for (int e = 0; e < MASK_W / 2; e++) begin
         if (CNT_W'(e) == cnt_q) begin
            a16 = op1_q[e*16 +: 16]; b16 = op2_q[e*16 +: 16]; act16 = mask_q[e*2];
         end
      end
      for (int e = 0; e < MASK_W / 4; e++) begin
         if (CNT_W'(e) == cnt_q) begin
            a32 = op1_q[e*32 +: 32]; b32 = op2_q[e*32 +: 32]; act32 = mask_q[e*4];
         end
      end
   end

   // Widen the element to 32 bits (sign- or zero-extended), take
   // magnitudes, and spot the two cases that bypass the iterative core.
   always_comb begin
      case (eew_q)
         VSEW_8: begin
            a_ext       = {{24{signed_q & a8[7]}}, a8};
            b_ext       = {{24{signed_q & b8[7]}}, b8};
            elem_active = act8;
            last_elem   = (cnt_q == CNT_W'(MASK_W - 1));
         end
         VSEW_16: begin
            a_ext       = {{16{signed_q & a16[15]}}, a16};
            b_ext       = {{16{signed_q & b16[15]}}, b16};
            elem_active = act16;
            last_elem   = (cnt_q == CNT_W'(MASK_W / 2 - 1));
         end
         default: begin
            a_ext       = a32;
            b_ext       = b32;
            elem_active = act32;
            last_elem   = (cnt_q == CNT_W'(MASK_W / 4 - 1));
         end
      endcase
      neg_a    = signed_q & a_ext[31];
      neg_b    = signed_q & b_ext[31];
      mag_a    = neg_a ? -a_ext : a_ext;
      mag_b    = neg_b ? -b_ext : b_ext;
      min_ext  = 32'hFFFF_FFFF << (w - 6'd1);
      div_zero = (b_ext == 32'd0);
      overflow = signed_q && (a_ext == min_ext) && (b_ext == 32'hFFFF_FFFF);
      special  = div_zero | overflow;
      if (div_zero) begin
         spec_res = (op_q == DIV_VDIV) ? 32'hFFFF_FFFF : a_ext;
      end else begin
         spec_res = (op_q == DIV_VDIV) ? a_ext : 32'd0;
      end
   end

   // Next-state and per-cycle control. An inactive element writes zero
   // directly from LOAD. Every other element writes in WRITE.
   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      write_en = 1'b0;
      wr_val   = '0;
      case (state_q)
         IDLE: if (bus.in_valid_i) state_d = LOAD;
         LOAD: begin
            if (!elem_active) begin
               write_en = 1'b1;
               state_d  = last_elem ? DONE : LOAD;
            end else if (special) begin
               state_d = WRITE;
            end else begin
               start   = 1'b1;
               state_d = ITER;
            end
         end
         ITER: if (core_done) state_d = WRITE;
         WRITE: begin
            write_en = 1'b1;
            if (spec_q)                wr_val = spec_res_q;
            else if (op_q == DIV_VDIV) wr_val = qneg_q ? -quotient : quotient;
            else                       wr_val = rneg_q ? -remainder : remainder;
            state_d = last_elem ? DONE : LOAD;
         end
         DONE: if (bus.out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Job registers. The element counter advances on every element write
   // and returns to 0 once the last element is written.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         res_q      <= '0;
         mask_q     <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         eew_q      <= VSEW_8;
         op_q       <= DIV_VDIV;
         signed_q   <= 1'b0;
         spec_q     <= 1'b0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         spec_res_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op1_q    <= bus.in_op1_i;
            op2_q    <= bus.in_op2_i;
            mask_q   <= bus.in_mask_i;
            eew_q    <= bus.in_eew_i;
            op_q     <= bus.in_op_i;
            signed_q <= bus.in_signed_i;
            res_q    <= '0;
         end
         if (state_q == LOAD) begin
            spec_q     <= special;
            spec_res_q <= spec_res;
            qneg_q     <= neg_a ^ neg_b;
            rneg_q     <= neg_a;
         end
         if (write_en) begin
            cnt_q <= last_elem ? '0 : cnt_q + CNT_W'(1);
            case (eew_q)
               VSEW_8:
                  for (int e = 0; e < MASK_W; e++)
                     if (CNT_W'(e) == cnt_q) res_q[e*8 +: 8] <= wr_val[7:0];
               VSEW_16:
                  for (int e = 0; e < MASK_W / 2; e++)
                     if (CNT_W'(e) == cnt_q) res_q[e*16 +: 16] <= wr_val[15:0];
               default:
                  for (int e = 0; e < MASK_W / 4; e++)
                     if (CNT_W'(e) == cnt_q) res_q[e*32 +: 32] <= wr_val;
            endcase
         end
      end
   end

   // The control word is opaque, so it is left out of reset.
   always_ff @(posedge clk_i) begin
      if (accept) ctrl_q <= bus.in_ctrl_i;
   end

   vproc_div_iter u_iter (
      .clk       (clk_i),
      .rst       (sync_rst_i),
      .start     (start),
      .width     (w),
      .op1       (mag_a),
      .op2       (mag_b),
      .quotient  (quotient),
      .remainder (remainder),
      .done      (core_done)
   );

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == DONE);
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.out_res_o   = res_q;
   assign bus.out_mask_o  = mask_q;
   assign bus.out_ctrl_o  = ctrl_q;

endmodule

// File: tb/tb_vproc_div_seq.sv
// Testbench for vproc_div_seq (64-bit words, 8-bit control).
// Directed and random jobs are checked against a plain-arithmetic model of
// the element results and of the cycle cost per element.
module tb_vproc_div_seq;
   import vproc_pkg::*;

   typedef logic [7:0] ctrl_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   vproc_div_seq_if #(.DIV_OP_W(64), .CTRL_T(ctrl_t)) bus ();

   vproc_div_seq #(.DIV_OP_W(64), .CTRL_T(ctrl_t)) dut (
      .clk_i      (clk),
      .sync_rst_i (rst),
      .bus        (bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: per-element integer division plus cycle cost. The
   // returned latency is the cycle index of out_valid, counting the
   // accept cycle as 0.
   function automatic void modelJob(input int w, input logic isRem, input logic sgn,
                                    input logic [63:0] op1, input logic [63:0] op2,
                                    input logic [7:0] mask,
                                    output logic [63:0] res, output int lat);
      longint unsigned lm, a, b, q, r;
      longint          sa, sb, half;
      int              n;
      n    = 64 / w;
      res  = '0;
      lat  = 1;
      lm   = (64'd1 << w) - 64'd1;
      half = 1;
      half = half << (w - 1);
      for (int e = 0; e < n; e++) begin
         a = (op1 >> (e * w)) & lm;
         b = (op2 >> (e * w)) & lm;
         if (!mask[(e * w) / 8]) begin
            lat += 1;
            continue;
         end
         sa = (sgn && a >= half) ? $signed(a) - 2 * half : $signed(a);
         sb = (sgn && b >= half) ? $signed(b) - 2 * half : $signed(b);
         if (b == 0) begin
            q = lm; r = a; lat += 2;
         end else if (sgn && sa == -half && sb == -1) begin
            q = a; r = 0; lat += 2;
         end else begin
            lat += w + 2;
            if (sgn) begin
               q = $unsigned(sa / sb);
               r = $unsigned(sa % sb);
            end else begin
               q = a / b;
               r = a % b;
            end
         end
         res = res | (((isRem ? r : q) & lm) << (e * w));
      end
   endfunction

   // Present one job, wait for the accept edge, then count cycles until
   // out_valid (bounded).
   task automatic applyStimulus(input vsew eew, input div_op op, input logic sgn,
                                input logic [63:0] op1, input logic [63:0] op2,
                                input logic [7:0] mask, input ctrl_t ctrl, output int cyc);
      @(negedge clk);
      bus.in_valid_i  = 1'b1;
      bus.in_eew_i    = eew;
      bus.in_op_i     = op;
      bus.in_signed_i = sgn;
      bus.in_op1_i    = op1;
      bus.in_op2_i    = op2;
      bus.in_mask_i   = mask;
      bus.in_ctrl_i   = ctrl;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      cyc = 1;
      while (bus.out_valid_o !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic finishJob(input string tag);
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready_i = 1'b0;
      checkOutput({tag, "_idle"}, 64'(bus.in_ready_o), 64'd1);
   endtask

   task automatic runJob(input string tag, input vsew eew, input div_op op, input logic sgn,
                         input logic [63:0] op1, input logic [63:0] op2, input logic [7:0] mask,
                         output logic [63:0] res, output int cyc);
      logic [63:0] expRes;
      int          expLat;
      ctrl_t       ctrl;
      ctrl = 8'($urandom);
      modelJob(8 << int'(eew), op == DIV_VREM, sgn, op1, op2, mask, expRes, expLat);
      applyStimulus(eew, op, sgn, op1, op2, mask, ctrl, cyc);
      res = bus.out_res_o;
      checkOutput({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
      checkOutput({tag, "_res"}, bus.out_res_o, expRes);
      checkOutput({tag, "_mask"}, 64'(bus.out_mask_o), 64'(mask));
      checkOutput({tag, "_ctrl"}, 64'(bus.out_ctrl_o), 64'(ctrl));
      checkOutput({tag, "_lat"}, 64'(cyc), 64'(expLat));
      finishJob(tag);
   endtask

   initial begin
      logic [63:0] res, op1, op2, expRes;
      logic [7:0]  mask;
      int          cyc, expLat, seen;
      vsew         eew;
      div_op       op;
      logic        sgn;

      rst             = 1'b1;
      bus.in_valid_i  = 1'b0;
      bus.in_ctrl_i   = '0;
      bus.in_eew_i    = VSEW_8;
      bus.in_op_i     = DIV_VDIV;
      bus.in_signed_i = 1'b0;
      bus.in_op1_i    = '0;
      bus.in_op2_i    = '0;
      bus.in_mask_i   = '0;
      bus.out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_valid", 64'(bus.out_valid_o), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
      checkOutput("rst_res", bus.out_res_o, 64'd0);
      checkOutput("rst_mask", 64'(bus.out_mask_o), 64'd0);
      checkOutput("rst_ready", 64'(bus.in_ready_o), 64'd1);

      $display("[TB] directed jobs");
      runJob("s32div", VSEW_32, DIV_VDIV, 1'b1, 64'h00000064_FFFFFFF9,
             64'h00000007_00000002, 8'hFF, res, cyc);
      checkOutput("s32div_const", res, 64'h0000000E_FFFFFFFD);
      checkOutput("s32div_cyc69", 64'(cyc), 64'd69);

      runJob("s32rem", VSEW_32, DIV_VREM, 1'b1, 64'h00000064_FFFFFFF9,
             64'h00000007_00000002, 8'hFF, res, cyc);
      checkOutput("s32rem_const", res[31:0], 64'hFFFFFFFF);

      runJob("dz8div", VSEW_8, DIV_VDIV, 1'b0, 64'h2525252525252525, 64'd0, 8'hFF, res, cyc);
      checkOutput("dz8div_const", res, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("dz8div_cyc", 64'(cyc), 64'd17);
      runJob("dz8rem", VSEW_8, DIV_VREM, 1'b0, 64'h2525252525252525, 64'd0, 8'hFF, res, cyc);
      checkOutput("dz8rem_const", res, 64'h2525252525252525);

      runJob("ov16div", VSEW_16, DIV_VDIV, 1'b1, 64'h8000800080008000,
             64'hFFFFFFFFFFFFFFFF, 8'hFF, res, cyc);
      checkOutput("ov16div_const", res, 64'h8000800080008000);
      checkOutput("ov16div_cyc", 64'(cyc), 64'd9);
      runJob("ov16rem", VSEW_16, DIV_VREM, 1'b1, 64'h8000800080008000,
             64'hFFFFFFFFFFFFFFFF, 8'hFF, res, cyc);
      checkOutput("ov16rem_const", res, 64'd0);

      op1 = {$urandom, $urandom};
      op2 = {$urandom, $urandom} | 64'h0101010101010101;
      runJob("mask0f", VSEW_8, DIV_VDIV, 1'b0, op1, op2, 8'h0F, res, cyc);
      checkOutput("mask0f_hi", 64'(res[63:32]), 64'd0);
      checkOutput("mask0f_cyc", 64'(cyc), 64'd45);

      runJob("mask00", VSEW_16, DIV_VREM, 1'b1, op1, op2, 8'h00, res, cyc);
      checkOutput("mask00_res", res, 64'd0);
      checkOutput("mask00_cyc", 64'(cyc), 64'd5);

      $display("[TB] consumer stall in DONE");
      op1 = {$urandom, $urandom};
      op2 = {$urandom, $urandom} | 64'h0001000100010001;
      modelJob(16, 1'b0, 1'b1, op1, op2, 8'hFF, expRes, expLat);
      applyStimulus(VSEW_16, DIV_VDIV, 1'b1, op1, op2, 8'hFF, 8'h5A, cyc);
      checkOutput("stall_lat", 64'(cyc), 64'(expLat));
      bus.in_valid_i = 1'b1;
      bus.in_op1_i   = ~op1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("stall%0d_valid", i), 64'(bus.out_valid_o), 64'd1);
         checkOutput($sformatf("stall%0d_ready", i), 64'(bus.in_ready_o), 64'd0);
         checkOutput($sformatf("stall%0d_res", i), bus.out_res_o, expRes);
         checkOutput($sformatf("stall%0d_ctrl", i), 64'(bus.out_ctrl_o), 64'h5A);
      end
      bus.in_valid_i = 1'b0;
      finishJob("stall");

      $display("[TB] reset during ITER");
      @(negedge clk);
      bus.in_valid_i  = 1'b1;
      bus.in_eew_i    = VSEW_32;
      bus.in_op_i     = DIV_VDIV;
      bus.in_signed_i = 1'b0;
      bus.in_op1_i    = 64'h12345678_9ABCDEF0;
      bus.in_op2_i    = 64'h00000003_00000005;
      bus.in_mask_i   = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("midrst_busy_before", 64'(bus.busy_o), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_ready", 64'(bus.in_ready_o), 64'd1);
      checkOutput("midrst_busy", 64'(bus.busy_o), 64'd0);
      checkOutput("midrst_valid", 64'(bus.out_valid_o), 64'd0);
      checkOutput("midrst_res", bus.out_res_o, 64'd0);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.out_valid_o !== 1'b0) seen = 1;
      end
      checkOutput("midrst_novalid", 64'(seen), 64'd0);

      $display("[TB] random jobs");
      for (int j = 0; j < 24; j++) begin
         eew  = vsew'(2'($urandom_range(2)));
         op   = div_op'(1'($urandom_range(1)));
         sgn  = 1'($urandom_range(1));
         op1  = {$urandom, $urandom};
         op2  = {$urandom, $urandom};
         mask = 8'($urandom);
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(7) == 0) op2[b*8 +: 8] = 8'h00;
         end
         if ($urandom_range(3) == 0) begin
            case (eew)
               VSEW_8:  begin op1[7:0]  = 8'h80;        op2[7:0]  = 8'hFF;        end
               VSEW_16: begin op1[15:0] = 16'h8000;     op2[15:0] = 16'hFFFF;     end
               default: begin op1[31:0] = 32'h80000000; op2[31:0] = 32'hFFFFFFFF; end
            endcase
         end
         runJob($sformatf("rnd%0d", j), eew, op, sgn, op1, op2, mask, res, cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
